// File: rtl/wide_ff_pkg.sv
// ---------------------------------------------------------------------------
// wide_ff_pkg
//   Shared defaults and helpers for the wide_ff_fifo block.
//   - WIDTH_DEF / DEPTH_DEF : default word width and entry count
//   - ptr_w(depth)          : pointer width. It carries one extra wrap bit so
//                             that full and empty stay distinguishable.
// ---------------------------------------------------------------------------
package wide_ff_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wide_ff_fifo_mem.sv
// ---------------------------------------------------------------------------
// wide_ff_fifo_mem
//   DEPTH x WIDTH register file. It has a write enable and no reset, so each
//   bit maps onto a plain enable flop.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write index
//     wdata  in   write data
//     raddr  in   read index
//     rdata  out  asynchronous read data, mem[raddr]
// ---------------------------------------------------------------------------
module wide_ff_fifo_mem
  import wide_ff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset. A reset here would
  // turn every bit into a resettable flop and add nothing. The top level
  // masks out_data while the FIFO is empty, so stale contents never
  // reach the output.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wide_ff_fifo.sv
// ---------------------------------------------------------------------------
// wide_ff_fifo
//   Small first-word fall-through FIFO. It uses a valid/ready handshake on
//   both sides and feeds a wide register stage. DEPTH must be a power of
//   two and at least 2.
//   Ports:
//     clk        in   clock; all state updates on posedge
//     clr_n      in   asynchronous active-low reset
//     flush      in   synchronous empty request; overrides push and pop
//     in_valid   in   producer offers in_data
//     in_ready   out  FIFO not full; depends on state only
//     in_data    in   write data
//     out_valid  out  FIFO not empty
//     out_ready  in   consumer takes out_data
//     out_data   out  oldest word; zero while empty
//     count      out  stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module wide_ff_fifo
  import wide_ff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push;
  logic             pop;

  assign in_ready  = (count != PW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? rdata : '0;

  // A flush drops any concurrent push. The write enable is gated the same
  // way, so the dropped word cannot land in storage either.
  wide_ff_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // NOTE: non-blocking assignments keep every register update
  // order-independent. Each register reads its pre-edge value regardless
  // of where the statement sits in the block.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // A simultaneous push and pop leaves count unchanged.
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_ff_fifo.sv
module tb_wide_ff_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             clr_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int checks   = 0;
  int failures = 0;

  wide_ff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each record holds the outputs expected for the current state, sampled
  // on the negedge. It also holds the inputs to drive for the following
  // posedge.
  typedef struct {
    logic       fl;
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic [2:0] e_count;
    logic       e_ov;
    logic       e_ir;
    logic [3:0] e_od;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [3:0] id,
                              input logic ordy, input logic [2:0] c, input logic ov,
                              input logic ir, input logic [3:0] od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_count = c; v.e_ov = ov; v.e_ir = ir; v.e_od = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] c, input logic ov,
                           input logic ir, input logic [3:0] od);
    check({tag, ".count"},     32'(count),     32'(c));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".out_data"},  32'(out_data),  32'(od));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [3:0] id, input logic ordy);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  initial begin
    //                 fl iv id     ordy cnt ov ir od
    // Fill with 6,5,2,9; a 5th word is offered but is not accepted.
    vecs[0]  = mk(0, 1, 4'h6, 0, 0, 0, 1, 4'h0);
    vecs[1]  = mk(0, 1, 4'h5, 0, 1, 1, 1, 4'h6);
    vecs[2]  = mk(0, 1, 4'h2, 0, 2, 1, 1, 4'h6);
    vecs[3]  = mk(0, 1, 4'h9, 0, 3, 1, 1, 4'h6);
    vecs[4]  = mk(0, 1, 4'hA, 0, 4, 1, 0, 4'h6);
    // Drain in order.
    vecs[5]  = mk(0, 0, 4'h0, 1, 4, 1, 0, 4'h6);
    vecs[6]  = mk(0, 0, 4'h0, 1, 3, 1, 1, 4'h5);
    vecs[7]  = mk(0, 0, 4'h0, 1, 2, 1, 1, 4'h2);
    vecs[8]  = mk(0, 0, 4'h0, 1, 1, 1, 1, 4'h9);
    vecs[9]  = mk(0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    // Refill with 1..4. At full, pop and push together: the push is blocked.
    vecs[10] = mk(0, 1, 4'h1, 0, 0, 0, 1, 4'h0);
    vecs[11] = mk(0, 1, 4'h2, 0, 1, 1, 1, 4'h1);
    vecs[12] = mk(0, 1, 4'h3, 0, 2, 1, 1, 4'h1);
    vecs[13] = mk(0, 1, 4'h4, 0, 3, 1, 1, 4'h1);
    vecs[14] = mk(0, 1, 4'h7, 1, 4, 1, 0, 4'h1);
    vecs[15] = mk(0, 1, 4'h7, 0, 3, 1, 1, 4'h2);
    vecs[16] = mk(0, 0, 4'h0, 1, 4, 1, 0, 4'h2);
    vecs[17] = mk(0, 0, 4'h0, 1, 3, 1, 1, 4'h3);
    vecs[18] = mk(0, 0, 4'h0, 1, 2, 1, 1, 4'h4);
    vecs[19] = mk(0, 0, 4'h0, 1, 1, 1, 1, 4'h7);
    vecs[20] = mk(0, 0, 4'h0, 0, 0, 0, 1, 4'h0);

    drive(0, 0, 4'h0, 0);

    // Reset asserted and released mid-cycle. The outputs must settle
    // before any clock edge.
    clr_n = 1'b1;
    #2 clr_n = 1'b0;
    #1 check_out("reset", 3'd0, 1'b0, 1'b1, 4'h0);
    #9 clr_n = 1'b1;

    // Table: fill, drain, full with simultaneous push/pop.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ov,
                vecs[i].e_ir, vecs[i].e_od);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
    end

    // Wrap: push 0 from empty with out_ready high. The pop is ignored.
    // Then push/pop pairs 1..9 at count 1 across the pointer wrap.
    @(negedge clk);
    drive(0, 1, 4'h0, 1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
      check($sformatf("wrap%0d.data", i), 32'(out_data), 32'(i - 1));
      drive(0, 1, 4'(i), 1);
    end
    @(negedge clk);
    check("wrap_last.count", 32'(count), 32'd1);
    check("wrap_last.data", 32'(out_data), 32'h9);
    drive(0, 0, 4'h0, 1);
    @(negedge clk);
    check_out("wrap_empty", 3'd0, 1'b0, 1'b1, 4'h0);

    // Flush at count 3 while a push is offered. The pushed word is dropped.
    drive(0, 1, 4'hA, 0);
    @(negedge clk) drive(0, 1, 4'hB, 0);
    @(negedge clk) drive(0, 1, 4'hC, 0);
    @(negedge clk);
    check_out("pre_flush", 3'd3, 1'b1, 1'b1, 4'hA);
    drive(1, 1, 4'hF, 0);
    @(negedge clk);
    check_out("flush", 3'd0, 1'b0, 1'b1, 4'h0);
    drive(0, 0, 4'h0, 1);
    @(negedge clk);
    check_out("post_flush", 3'd0, 1'b0, 1'b1, 4'h0);

    // Reset asserted mid-burst. Afterwards the FIFO recovers with a
    // fresh word.
    drive(0, 1, 4'h3, 0);
    @(negedge clk) drive(0, 1, 4'h4, 0);
    @(negedge clk) drive(0, 0, 4'h0, 0);
    check("burst.count", 32'(count), 32'd2);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 check_out("mid_reset", 3'd0, 1'b0, 1'b1, 4'h0);
    @(negedge clk) clr_n = 1'b1;
    drive(0, 1, 4'h5, 0);
    @(negedge clk);
    check_out("recover", 3'd1, 1'b1, 1'b1, 4'h5);
    drive(0, 0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
